// File: rtl/div_dispatch.sv
// div_dispatch: request FIFO, issue FSM and response register wrapped around
// an iterative divider with a start/done handshake. Requests with a zero
// divisor are answered locally with all-ones and never reach the divider.
module div_dispatch #(
  parameter int N     = 8,
  parameter int TAG_W = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_dividend,
  input  logic [N-1:0]     req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             div_start,
  output logic [N-1:0]     div_dividend,
  output logic [N-1:0]     div_divisor,
  input  logic [N-1:0]     div_result,
  input  logic             div_done,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state_reg, state_next;

  // FIFO storage (no reset needed: validity is tracked by count_reg)
  logic [N-1:0]     fifo_dividend [DEPTH];
  logic [N-1:0]     fifo_divisor  [DEPTH];
  logic [TAG_W-1:0] fifo_tag      [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic fifo_empty, fifo_full, push, pop;
  logic [N-1:0]     head_dividend, head_divisor;
  logic [TAG_W-1:0] head_tag;

  // Operation registers for the op currently being serviced
  logic [N-1:0]     op_dividend_reg, op_divisor_reg, result_reg;
  logic [TAG_W-1:0] tag_reg;
  // High only from the second WAIT cycle on, so a done left over from the
  // previous op is ignored while the divider is still registering the start
  logic             armed_reg;
  logic             capture;

  assign fifo_empty    = (count_reg == '0);
  assign fifo_full     = (count_reg == CW'(DEPTH));
  assign req_ready     = !fifo_full;
  assign push          = req_valid && req_ready;
  assign head_dividend = fifo_dividend[rd_ptr_reg];
  assign head_divisor  = fifo_divisor[rd_ptr_reg];
  assign head_tag      = fifo_tag[rd_ptr_reg];
  assign capture       = (state_reg == WAIT) && armed_reg && div_done;

  // Write accepted requests into the FIFO slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dividend[wr_ptr_reg] <= req_dividend;
      fifo_divisor[wr_ptr_reg]  <= req_divisor;
      fifo_tag[wr_ptr_reg]      <= req_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and pop decision
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = (head_divisor == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT:  if (capture) state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/tag/result registers; div_result is only sampled on capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_dividend_reg <= '0;
      op_divisor_reg  <= '0;
      result_reg      <= '0;
      tag_reg         <= '0;
      armed_reg       <= 1'b0;
    end else begin
      armed_reg <= (state_reg == WAIT);
      if (pop) begin
        op_dividend_reg <= head_dividend;
        op_divisor_reg  <= head_divisor;
        tag_reg         <= head_tag;
        if (head_divisor == '0) result_reg <= '1;
      end
      if (capture) result_reg <= div_result;
    end
  end

  assign div_start    = (state_reg == ISSUE);
  assign div_dividend = op_dividend_reg;
  assign div_divisor  = op_divisor_reg;
  assign resp_valid   = (state_reg == RESP);
  assign resp_result  = result_reg;
  assign resp_tag     = tag_reg;
  assign busy         = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_div_dispatch.sv
// Testbench for div_dispatch: attached divider model with a late-clearing done
// flag, a queue-based reference of expected responses/issues, and directed
// latency and ordering checks.
module tb_div_dispatch;
  localparam int N = 8, TAG_W = 2, DEPTH = 4, LAT = 4;

  logic             clk = 1'b0, reset = 1'b0;
  logic             req_valid, req_ready;
  logic [N-1:0]     req_dividend, req_divisor;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [N-1:0]     resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic             div_start, div_done, busy;
  logic [N-1:0]     div_dividend, div_divisor, div_result;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  div_dispatch #(.N(N), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_result(div_result), .div_done(div_done), .busy(busy)
  );

  // Divider model: registers start one cycle late, so done from the previous
  // op stays high through the ISSUE cycle and the first WAIT cycle.
  logic         start_q, running;
  int           cnt;
  logic [N-1:0] da, db;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 0; running <= 0; cnt <= 0;
      div_done <= 0; div_result <= 0; da <= 0; db <= 0;
    end else begin
      start_q <= div_start;
      if (start_q) begin
        da <= div_dividend; db <= div_divisor;
        div_done <= 0; running <= 1; cnt <= LAT;
      end else if (running) begin
        if (cnt == 0) begin
          running <= 0; div_done <= 1;
          div_result <= (db == 0) ? '1 : da / db;
        end else cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: expected responses in acceptance order, expected issues
  typedef struct packed { logic [N-1:0] q; logic [TAG_W-1:0] tag; } resp_t;
  typedef struct packed { logic [N-1:0] dd; logic [N-1:0] dv; } iss_t;
  resp_t            exp_q[$];
  iss_t             iss_q[$];
  logic [N-1:0]     got_res[$];
  logic [TAG_W-1:0] got_tag[$];
  logic             prev_stall, prev_start;
  logic [N-1:0]     prev_res, cur_dd, cur_dv;
  logic [TAG_W-1:0] prev_tag;

  // Compare process: every cycle, mid-cycle, against the reference queues
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete(); iss_q.delete();
      prev_stall = 0; prev_start = 0;
    end else begin
      if (div_start) begin
        check("start_single_cycle", prev_start, 0);
        if (iss_q.size() == 0) check("start_without_request", div_start, 0);
        else begin
          check("issue_dividend", div_dividend, iss_q[0].dd);
          check("issue_divisor", div_divisor, iss_q[0].dv);
          cur_dd = iss_q[0].dd; cur_dv = iss_q[0].dv;
          void'(iss_q.pop_front());
        end
      end
      if (start_q) begin
        check("operand_hold_dividend", div_dividend, cur_dd);
        check("operand_hold_divisor", div_divisor, cur_dv);
      end
      prev_start = div_start;
      if (resp_valid) begin
        if (prev_stall) begin
          check("stall_result_stable", resp_result, prev_res);
          check("stall_tag_stable", resp_tag, prev_tag);
        end
        if (exp_q.size() == 0) check("resp_without_request", resp_valid, 0);
        else begin
          check("resp_result", resp_result, exp_q[0].q);
          check("resp_tag", resp_tag, exp_q[0].tag);
          if (resp_ready) begin
            $display("resp: result=%0d tag=%0d", resp_result, resp_tag);
            got_res.push_back(resp_result); got_tag.push_back(resp_tag);
            void'(exp_q.pop_front());
          end
        end
      end else if (prev_stall) check("resp_valid_held", resp_valid, 1);
      prev_stall = resp_valid && !resp_ready;
      prev_res = resp_result; prev_tag = resp_tag;
      if (req_valid && req_ready) begin
        $display("push: %0d / %0d tag=%0d", req_dividend, req_divisor, req_tag);
        exp_q.push_back('{q: (req_divisor == 0) ? '1 : req_dividend / req_divisor, tag: req_tag});
        if (req_divisor != 0) iss_q.push_back('{dd: req_dividend, dv: req_divisor});
      end
    end
  end

  // Drive one request; returns at posedge+1 after the accepting edge
  task automatic push_req(input int dd, input int dv, input int tg);
    logic ok;
    int   tries = 0;
    req_valid = 1; req_dividend = N'(dd); req_divisor = N'(dv); req_tag = TAG_W'(tg);
    do begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1; tries++;
    end while (!ok && tries < 100);
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: request %0d/%0d not accepted", dd, dv);
    end
    req_valid = 0;
  endtask

  task automatic wait_resp(input int max, output int n);
    n = 0;
    while (!resp_valid && n < max) begin @(posedge clk); #1; n++; end
    if (!resp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_timeout: got 0 required 1 after %0d cycles", n);
    end
  endtask

  task automatic wait_got(input int k, input int max);
    int n = 0;
    while (got_res.size() < k && n < max) begin @(posedge clk); #1; n++; end
    check("response_count", got_res.size(), k);
  endtask

  initial begin
    int n;
    logic [N-1:0] exp_res[5];
    logic [TAG_W-1:0] exp_tag[5];
    req_valid = 0; req_dividend = 0; req_divisor = 0; req_tag = 0; resp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_dividend", div_dividend, 0);
    check("rst_div_divisor", div_divisor, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #1;

    // Single op 200/7 -> 28, tag 2; start at T+2, resp 8 cycles after start
    push_req(200, 7, 2);
    check("t1_no_start_T1", div_start, 0);
    @(posedge clk); #1;
    check("t1_start_T2", div_start, 1);
    check("t1_dividend", div_dividend, 200);
    check("t1_divisor", div_divisor, 7);
    wait_resp(50, n);
    check("t1_latency", n, 8);
    check("t1_result", resp_result, 28);
    check("t1_tag", resp_tag, 2);
    @(posedge clk); #1;
    check("t1_resp_done", resp_valid, 0);
    check("t1_idle", busy, 0);

    // Divide by zero: 55/0 -> 255 at T+2, no divider involvement
    push_req(55, 0, 1);
    check("t2_not_valid_T1", resp_valid, 0);
    @(posedge clk); #1;
    check("t2_valid_T2", resp_valid, 1);
    check("t2_result", resp_result, 255);
    check("t2_tag", resp_tag, 1);
    check("t2_no_start", div_start, 0);
    @(posedge clk); #1;

    // Fill, ordering and backpressure
    resp_ready = 0;
    got_res.delete(); got_tag.delete();
    push_req(13, 3, 0);
    push_req(100, 10, 1);
    push_req(9, 0, 2);
    push_req(255, 1, 3);
    push_req(0, 5, 0);
    check("t3_full_ready", req_ready, 0);
    check("t3_busy", busy, 1);
    wait_resp(50, n);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", resp_valid, 1);
      check("t4_hold_result", resp_result, 4);
      check("t4_hold_tag", resp_tag, 0);
      check("t4_no_start", div_start, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1;
    wait_got(5, 300);
    exp_res = '{4, 10, 255, 255, 0};
    exp_tag = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5 && i < got_res.size(); i++) begin
      check("t3_order_result", got_res[i], exp_res[i]);
      check("t3_order_tag", got_tag[i], exp_tag[i]);
    end
    check("t3_ready_again", req_ready, 1);

    // Stale done: second op sees done=1 from the first while starting
    got_res.delete(); got_tag.delete();
    push_req(50, 5, 3);
    push_req(90, 3, 1);
    wait_got(2, 100);
    if (got_res.size() >= 2) begin
      check("t5_first", got_res[0], 10);
      check("t5_second", got_res[1], 30);
      check("t5_second_tag", got_tag[1], 1);
    end

    // Asynchronous reset in WAIT with two queued requests
    repeat (2) @(posedge clk);
    #1;
    push_req(20, 4, 0);
    push_req(30, 3, 1);
    push_req(40, 2, 2);
    @(posedge clk); #3;
    reset = 0;
    #1;
    check("t6_resp_valid", resp_valid, 0);
    check("t6_div_start", div_start, 0);
    check("t6_div_dividend", div_dividend, 0);
    check("t6_div_divisor", div_divisor, 0);
    check("t6_req_ready", req_ready, 1);
    check("t6_busy", busy, 0);
    @(posedge clk); @(posedge clk); #2 reset = 1;
    @(posedge clk); #1;
    check("t6_post_busy", busy, 0);
    check("t6_post_ready", req_ready, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid || div_start) n++;
      @(posedge clk); #1;
    end
    check("t6_no_replay", n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
